// File: rtl/fire_sequencer.sv
// Burst controller for the coil drive chain: debounces fire, drives open-loop then
// closed-loop, enforces on/off times and latches a fault after repeated lock failures.
module fire_sequencer #(
  parameter int unsigned ON_CYCLES       = 20000,
  parameter int unsigned OFF_CYCLES      = 2700000,
  parameter int unsigned PRIME_TIMEOUT   = 4096,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MIN_PERIOD      = 20,
  parameter int unsigned MAX_PERIOD      = 200,
  parameter int unsigned INITIAL_PERIOD  = 56,
  parameter int unsigned FAIL_LIMIT      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fire_n,
  input  logic        fault_clear,
  input  logic        period_valid,
  input  logic [31:0] period_in,
  output logic        drive_enable,
  output logic        fc_reset,
  output logic        sg_reset,
  output logic        set_period,
  output logic [31:0] period_out,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPrime    = 3'd1,
    StLocked   = 3'd2,
    StCooldown = 3'd3,
    StFault    = 3'd4
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_e      state_q, state_d;
  logic        fire_meta_q, fire_sync_n_q, fire_sync;
  logic        fire_db_q, fire_db_d;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic        pv_q;
  logic [31:0] pin_q;
  logic        pin_ok;
  logic [31:0] on_cnt_q, on_cnt_d, prime_cnt_q, prime_cnt_d;
  logic [31:0] off_cnt_q, off_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [31:0] on_next, prime_next, off_next;
  logic        on_expire, prime_expire, off_expire;
  logic        set_period_q, set_period_d;
  logic [31:0] period_out_q, period_out_d;
  logic        drive_q, fault_q, drive_d;

  assign fire_sync = ~fire_sync_n_q;

  always_comb begin
    db_cnt_d  = '0;
    fire_db_d = fire_db_q;
    if (fire_sync != fire_db_q) begin
      db_cnt_d = sat_inc(db_cnt_q);
      if (db_cnt_d >= 32'(DEBOUNCE_CYCLES)) begin
        fire_db_d = fire_sync;
        db_cnt_d  = '0;
      end
    end
  end

  // Feedback is registered once before the FSM acts on it.
  assign pin_ok = pv_q && (pin_q >= 32'(MIN_PERIOD)) && (pin_q <= 32'(MAX_PERIOD));

  assign on_next      = sat_inc(on_cnt_q);
  assign prime_next   = sat_inc(prime_cnt_q);
  assign off_next     = sat_inc(off_cnt_q);
  assign on_expire    = on_next >= 32'(ON_CYCLES);
  assign prime_expire = prime_next >= 32'(PRIME_TIMEOUT);
  assign off_expire   = off_next >= 32'(OFF_CYCLES);

  always_comb begin
    state_d      = state_q;
    on_cnt_d     = on_cnt_q;
    prime_cnt_d  = prime_cnt_q;
    off_cnt_d    = off_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    set_period_d = 1'b0;
    period_out_d = period_out_q;
    unique case (state_q)
      StIdle: begin
        if (fire_db_q) begin
          state_d     = StPrime;
          on_cnt_d    = '0;
          prime_cnt_d = '0;
        end
      end
      StPrime, StLocked: begin
        on_cnt_d    = on_next;
        prime_cnt_d = prime_next;
        // Priority: release, on-time expiry, prime timeout, feedback.
        if (!fire_db_q || on_expire) begin
          state_d   = StCooldown;
          off_cnt_d = '0;
        end else if (state_q == StPrime && prime_expire) begin
          state_d    = StCooldown;
          off_cnt_d  = '0;
          fail_cnt_d = sat_inc(fail_cnt_q);
        end else if (pin_ok) begin
          state_d      = StLocked;
          set_period_d = 1'b1;
          period_out_d = pin_q;
          fail_cnt_d   = '0;
        end
      end
      StCooldown: begin
        off_cnt_d = off_next;
        if (off_expire) begin
          if (fail_cnt_q >= 32'(FAIL_LIMIT)) begin
            state_d = StFault;
          end else if (fire_db_q) begin
            state_d     = StPrime;
            on_cnt_d    = '0;
            prime_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFault: begin
        if (fault_clear && !fire_db_q) begin
          state_d    = StIdle;
          fail_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign drive_d = (state_d == StPrime) || (state_d == StLocked);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fire_meta_q   <= 1'b1;
      fire_sync_n_q <= 1'b1;
      fire_db_q     <= 1'b0;
      db_cnt_q      <= '0;
      pv_q          <= 1'b0;
      pin_q         <= '0;
      state_q       <= StIdle;
      on_cnt_q      <= '0;
      prime_cnt_q   <= '0;
      off_cnt_q     <= '0;
      fail_cnt_q    <= '0;
      set_period_q  <= 1'b0;
      period_out_q  <= 32'(INITIAL_PERIOD);
      drive_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      fire_meta_q   <= fire_n;
      fire_sync_n_q <= fire_meta_q;
      fire_db_q     <= fire_db_d;
      db_cnt_q      <= db_cnt_d;
      pv_q          <= period_valid;
      pin_q         <= period_in;
      state_q       <= state_d;
      on_cnt_q      <= on_cnt_d;
      prime_cnt_q   <= prime_cnt_d;
      off_cnt_q     <= off_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      set_period_q  <= set_period_d;
      period_out_q  <= period_out_d;
      drive_q       <= drive_d;
      fault_q       <= (state_d == StFault);
    end
  end

  assign drive_enable = drive_q;
  assign fc_reset     = ~drive_q;
  assign sg_reset     = ~drive_q;
  assign set_period   = set_period_q;
  assign period_out   = period_out_q;
  assign fault        = fault_q;
  assign state        = state_q;

endmodule
